bit_count_engine: RTL

BIT_COUNT_ENGINE -- requirements
Module: bit_count_engine

---
 rtl/bit_count_engine.sv | 96 +++++++++
 1 files changed

// File: rtl/bit_count_engine.sv
// Sequential bit counter: popcount, zero count, trailing-zero and leading-zero count
// by shifting the operand one position per clock through a three-state FSM.
module bit_count_engine #(
    parameter int N = 16
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [N-1:0]             data_in,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N+1)-1:0]   result
);

    localparam int CW = $clog2(N+1);
    localparam logic [CW-1:0] N_CW = CW'(N);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [N-1:0]    sreg;
    logic [CW-1:0]   count;
    logic [CW-1:0]   idx;
    logic [1:0]      mode_q;
    logic            scan_end;

    // Popcount modes stop once no set bits remain; zero-run modes stop on the first set bit or after N.
    always_comb begin
        scan_end = 1'b0;
        case (mode_q)
            2'b00, 2'b01: scan_end = (sreg == '0);
            2'b10:        scan_end = sreg[0]   || (idx == N_CW);
            default:      scan_end = sreg[N-1] || (idx == N_CW);
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)    state_nx = SCAN;
            SCAN:    if (scan_end) state_nx = DONE;
            DONE:    if (!start)   state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!areset_n) state <= IDLE;
        else           state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            sreg   <= '0;
            count  <= '0;
            idx    <= '0;
            mode_q <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg   <= (mode == 2'b01) ? ~data_in : data_in;
                        count  <= '0;
                        idx    <= '0;
                        mode_q <= mode;
                    end
                end
                SCAN: begin
                    if (!scan_end) begin
                        if (!mode_q[1]) begin
                            count <= count + CW'(sreg[0]);
                            sreg  <= sreg >> 1;
                        end else begin
                            count <= count + ONE;
                            idx   <= idx + ONE;
                            sreg  <= mode_q[0] ? (sreg << 1) : (sreg >> 1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state == SCAN);
    assign done   = (state == DONE);
    assign result = count;

endmodule
